// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32M divide unit.
//   XLEN        : default operand/result width
//   DIV_OP_*    : DivOp encodings (DIV, DIVU, REM, REMU)
//   div_state_t : divider controller states
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/riscv_div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// Ports:
//   rem      : current partial remainder (XLEN+1 bits)
//   quo      : current quotient/dividend shift register
//   divisor  : divisor magnitude
//   rem_next : partial remainder after this iteration
//   quo_next : quotient register after this iteration (new bit in LSB)
module riscv_div_step #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;
    logic          borrow;

    // {rem,quo} shifted left by one: the dividend MSB moves into the remainder.
    assign shifted = {rem[XLEN-1:0], quo[XLEN-1]};
    assign trial   = shifted - {1'b0, divisor};

    // A set remainder MSB means the shifted value exceeds any divisor,
    // so the subtraction cannot borrow in that case.
    assign borrow   = trial[XLEN] & ~rem[XLEN];
    assign rem_next = borrow ? shifted : trial;
    assign quo_next = {quo[XLEN-2:0], ~borrow};

endmodule

// File: rtl/riscv_div_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Fixed latency: Start accepted at edge e0, one iteration per edge e1..e(ITER),
// sign fix-up and result register at the following edge, Done pulses after it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   Start      : request a divide (sampled only when idle)
//   DivOp      : 00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled with Start)
//   SrcA, SrcB : dividend, divisor (sampled with Start)
//   Flush      : synchronous abort; wins over Start
//   Busy       : operation in flight, stalls the pipeline
//   Done       : one-cycle pulse, DivResult valid
//   DivResult  : quotient or remainder, held until the next completion
// ITER must equal XLEN.
//
// state    | meaning
// DIV_IDLE | waiting for Start
// DIV_CALC | one restoring step per clock, counter counts down to 0
// DIV_FIX  | sign/div-by-zero fix-up, result registered
module riscv_div_unit #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int ITER = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start,
    input  logic [1:0]      DivOp,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            Flush,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] DivResult
);

    import riscv_pkg::*;

    localparam int              CNT_W    = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER - 1);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       div_op;
    logic             sign_a;
    logic             sign_b;
    logic             div_zero;
    logic [XLEN-1:0]  divisor;
    logic [XLEN-1:0]  quo;
    logic [XLEN:0]    rem;

    logic             op_signed;
    logic             accept;
    logic [XLEN-1:0]  abs_a;
    logic [XLEN-1:0]  abs_b;
    logic [XLEN:0]    rem_step;
    logic [XLEN-1:0]  quo_step;
    logic [XLEN-1:0]  rem_lo;
    logic [XLEN-1:0]  result_c;

    assign op_signed = ~DivOp[0];
    assign abs_a     = (op_signed && SrcA[XLEN-1]) ? -SrcA : SrcA;
    assign abs_b     = (op_signed && SrcB[XLEN-1]) ? -SrcB : SrcB;
    assign accept    = (state == DIV_IDLE) && Start && !Flush;
    assign Busy      = (state != DIV_IDLE);
    assign rem_lo    = rem[XLEN-1:0];

    riscv_div_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (accept) state_next = DIV_CALC;
            DIV_CALC: begin
                if (Flush)            state_next = DIV_IDLE;
                else if (cnt == '0)   state_next = DIV_FIX;
            end
            DIV_FIX:  state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    // With a zero divisor every trial subtraction succeeds, so the remainder
    // ends up equal to |SrcA|; the REM sign fix-up then restores SrcA exactly.
    // Only the quotient needs an explicit override. Signed overflow
    // (MIN / -1) wraps through the negation with no special case.
    always_comb begin
        result_c = quo;
        case (div_op)
            DIV_OP_DIVU: result_c = div_zero ? '1 : quo;
            DIV_OP_DIV:  result_c = div_zero ? '1 : ((sign_a ^ sign_b) ? -quo : quo);
            DIV_OP_REMU: result_c = rem_lo;
            DIV_OP_REM:  result_c = sign_a ? -rem_lo : rem_lo;
            default:     result_c = quo;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            div_op    <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            div_zero  <= 1'b0;
            divisor   <= '0;
            quo       <= '0;
            rem       <= '0;
            Done      <= 1'b0;
            DivResult <= '0;
        end else begin
            Done <= (state == DIV_FIX) && !Flush;
            case (state)
                DIV_IDLE: begin
                    if (accept) begin
                        div_op   <= DivOp;
                        sign_a   <= op_signed & SrcA[XLEN-1];
                        sign_b   <= op_signed & SrcB[XLEN-1];
                        div_zero <= (SrcB == '0);
                        divisor  <= abs_b;
                        quo      <= abs_a;
                        rem      <= '0;
                        cnt      <= CNT_LOAD;
                    end
                end
                DIV_CALC: begin
                    if (!Flush) begin
                        rem <= rem_step;
                        quo <= quo_step;
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DIV_FIX: begin
                    if (!Flush) DivResult <= result_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_div_unit.sv
module tb_riscv_div_unit;

    import riscv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 33;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         Start = 1'b0;
    logic         Flush = 1'b0;
    logic [1:0]   DivOp = 2'b00;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic         Busy;
    logic         Done;
    logic [W-1:0] DivResult;

    riscv_div_unit #(.XLEN(W), .ITER(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .DivOp     (DivOp),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Flush     (Flush),
        .Busy      (Busy),
        .Done      (Done),
        .DivResult (DivResult)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        int unsigned  due;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    int unsigned  cyc = 0;
    logic [W-1:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // RISC-V M-extension semantics from plain 64-bit arithmetic.
    function automatic logic [W-1:0] ref_model(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        longint sa, sbv, r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            DIV_OP_DIV: begin
                if (b == 0) return '1;
                r = sa / sbv;
                return r[W-1:0];
            end
            DIV_OP_DIVU: return (b == 0) ? '1 : a / b;
            DIV_OP_REM: begin
                if (b == 0) return a;
                r = sa % sbv;
                return r[W-1:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Monitor: compares every cycle against the scoreboard head.
    always @(negedge clk) begin
        logic exp_done;
        exp_done = (sb.size() > 0) && (sb[0].due == cyc);
        check("busy", {31'b0, Busy}, {31'b0, (sb.size() > 0) && (cyc < sb[0].due)});
        check("done", {31'b0, Done}, {31'b0, exp_done});
        if (exp_done) begin
            check($sformatf("result op=%0d a=%h b=%h", sb[0].op, sb[0].a, sb[0].b),
                  DivResult, sb[0].res);
            last_res = sb[0].res;
            void'(sb.pop_front());
        end else begin
            check("hold", DivResult, last_res);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL wait_idle: Busy still %b after %0d cycles", Busy, n);
        end
    endtask

    task automatic issue(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        wait_idle();
        DivOp = op;
        SrcA  = a;
        SrcB  = b;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        e.res = ref_model(op, a, b);
        e.due = cyc + LAT;
        e.op  = op;
        e.a   = a;
        e.b   = b;
        sb.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(1, 100);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset busy", {31'b0, Busy}, '0);
        check("reset done", {31'b0, Done}, '0);
        check("reset result", DivResult, '0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        issue(DIV_OP_DIV,  32'd100, 32'd7);
        issue(DIV_OP_REM,  32'd100, 32'd7);
        issue(DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2);
        issue(DIV_OP_REM,  32'hFFFF_FFF9, 32'd2);
        issue(DIV_OP_REMU, 32'hFFFF_FFF9, 32'd2);
        issue(DIV_OP_DIVU, 32'h1234_5678, 32'd0);
        issue(DIV_OP_REM,  32'h1234_5678, 32'd0);
        issue(DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        issue(DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
        issue(DIV_OP_DIV,  32'hFFFF_FF9C, 32'h0000_0000);

        // Flush part-way through CALC: no Done, result held.
        issue(DIV_OP_DIVU, 32'd50, 32'd5);
        repeat (9) @(negedge clk);
        Flush = 1'b1;
        @(posedge clk);
        #1;
        Flush = 1'b0;
        sb.delete();
        @(negedge clk);
        issue(DIV_OP_DIVU, 32'd50, 32'd5);
        wait_idle();
        @(negedge clk);

        // Flush together with Start while idle: Start not accepted.
        DivOp = DIV_OP_DIVU;
        SrcA  = 32'd9;
        SrcB  = 32'd3;
        Start = 1'b1;
        Flush = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        Flush = 1'b0;
        repeat (2) @(negedge clk);

        // Start while busy is ignored.
        issue(DIV_OP_DIVU, 32'd1000, 32'd10);
        repeat (5) @(negedge clk);
        DivOp = DIV_OP_DIV;
        SrcA  = 32'd7;
        SrcB  = 32'd1;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        wait_idle();
        @(negedge clk);

        // Asynchronous reset mid-CALC.
        issue(DIV_OP_DIVU, 32'd12345, 32'd7);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy", {31'b0, Busy}, '0);
        check("midreset done", {31'b0, Done}, '0);
        check("midreset result", DivResult, '0);
        sb.delete();
        last_res = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 200; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(op, a, b);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        check("scoreboard drained", sb.size(), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
